fp_mul_pipe: RTL and testbench

- Parametrised, fully pipelined IEEE-754-style floating-point multiplier with valid/ready handshake, sign handling, special-value handling, exception flags and a sideband tag.
- Successor to the single-precision, enable-driven multiplier.
- Sits in the fast-inverse-square-root datapath; its tag replaces the old registered copy of operand 1, which Newton-iteration stages need downstream.

---
 rtl/fp_mul_pkg.sv | 37 +++
 rtl/fp_mul_round_pack.sv | 81 ++++++++
 rtl/fp_mul_pipe.sv | 140 ++++++++++++++
 tb/tb_fp_mul_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
// Stage structs are built in fp_mul_pipe from fp_hdr_t, because their field widths follow the module parameters.
package fp_mul_pkg;

  localparam int unsigned DEF_EXP_W = 8;
  localparam int unsigned DEF_MAN_W = 23;
  localparam int unsigned DEF_BIAS  = (1 << (DEF_EXP_W - 1)) - 1;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_t;

  // Width-independent part of every stage register.
  typedef struct packed {
    logic      sign;
    fp_class_t cls_a;
    fp_class_t cls_b;
  } fp_hdr_t;

  // Subnormals are flushed, so an all-zero exponent is treated as zero.
  function automatic fp_class_t classify(logic exp_zero, logic exp_ones, logic man_zero);
    if (exp_zero) return ZERO;
    if (exp_ones) return man_zero ? INF : NAN;
    return NORM;
  endfunction

  // Quiet NaN: sign 0, exponent all ones, only the mantissa MSB set. Result in low bits.
  function automatic logic [63:0] canon_nan(int unsigned exp_w, int unsigned man_w);
    logic [63:0] v;
    v = (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_mul_round_pack.sv
// Stage-3 normalise, round, range check and pack, including special-value results.
// Rounding is round-to-nearest-even when FP_MUL_RNE_EN is defined, truncation otherwise.
module fp_mul_round_pack
  import fp_mul_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W,
  localparam int unsigned W    = 1 + EXP_W + MAN_W,
  localparam int unsigned EW   = EXP_W + 2,
  localparam int unsigned PW   = 2 * (MAN_W + 1)
) (
  input  logic            sign_i,
  input  fp_class_t       cls_a_i,
  input  fp_class_t       cls_b_i,
  input  logic [EW-1:0]   esum_i,
  input  logic [PW-1:0]   prod_i,
  output logic [W-1:0]    data_o,
  output logic            ovf_o,
  output logic            unf_o,
  output logic            inv_o
);

  localparam int unsigned MW1 = MAN_W + 1;
  localparam logic [W-1:0] QNAN = W'(canon_nan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  logic [PW-1:0]        norm;
  logic [MAN_W:0]       rnd;
  logic signed [EW-1:0] exp_n;
  logic signed [EW-1:0] exp_r;
  logic [W-1:0]         inf_val;
  logic [W-1:0]         zero_val;
  logic                 is_inv;
  logic                 unused_bits;

  always_comb begin
    // Product is in [1,4); bring the leading one to the top bit.
    norm  = prod_i[PW-1] ? prod_i : {prod_i[PW-2:0], 1'b0};
    exp_n = esum_i + EW'(prod_i[PW-1]);
`ifdef FP_MUL_RNE_EN
    // Guard is norm[MAN_W], sticky the bits below it, LSB norm[MAN_W+1].
    rnd = {1'b0, norm[PW-2 -: MAN_W]}
        + MW1'(norm[MAN_W] & ((|norm[MAN_W-1:0]) | norm[MAN_W+1]));
    unused_bits = norm[PW-1];
`else
    rnd = {1'b0, norm[PW-2 -: MAN_W]};
    unused_bits = ^{norm[PW-1], norm[MAN_W:0]};
`endif
    // A carry out leaves the stored mantissa at zero, i.e. 1.0 * 2^(e+1).
    exp_r = exp_n + EW'(rnd[MAN_W]);
  end

  assign inf_val  = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign zero_val = {sign_i, {(W-1){1'b0}}};
  assign is_inv   = (cls_a_i == NAN) || (cls_b_i == NAN)
                 || (cls_a_i == INF && cls_b_i == ZERO)
                 || (cls_a_i == ZERO && cls_b_i == INF);

  always_comb begin
    data_o = {sign_i, exp_r[EXP_W-1:0], rnd[MAN_W-1:0]};
    ovf_o  = 1'b0;
    unf_o  = 1'b0;
    inv_o  = 1'b0;
    if (is_inv) begin
      data_o = QNAN;
      inv_o  = 1'b1;
    end else if (cls_a_i == INF || cls_b_i == INF) begin
      data_o = inf_val;
    end else if (cls_a_i == ZERO || cls_b_i == ZERO) begin
      data_o = zero_val;
    end else if (exp_r >= EXP_MAX) begin
      data_o = inf_val;
      ovf_o  = 1'b1;
    end else if (exp_r <= EXP_ZERO) begin
      data_o = zero_val;
      unf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control and a sideband tag.
// Define FP_MUL_RNE_EN for round-to-nearest-even; the default build truncates.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W,
  parameter int unsigned TAG_W = 32,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_inv
);

  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned PW = 2 * (MAN_W + 1);
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);

  typedef struct packed {
    fp_hdr_t            hdr;
    logic [EW-1:0]      esum;
    logic [MAN_W-1:0]   ma;
    logic [MAN_W-1:0]   mb;
    logic [TAG_W-1:0]   tag;
  } s1_t;

  typedef struct packed {
    fp_hdr_t            hdr;
    logic [EW-1:0]      esum;
    logic [PW-1:0]      prod;
    logic [TAG_W-1:0]   tag;
  } s2_t;

  logic             adv;
  logic             s1_valid_q;
  logic             s2_valid_q;
  logic             out_valid_q;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic [W-1:0]     res_data;
  logic             res_ovf, res_unf, res_inv;
  logic [W-1:0]     out_data_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_ovf_q, out_unf_q, out_inv_q;

  // The whole pipe moves together; a stalled output freezes every stage, bubbles included.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign ea = in_a[W-2 -: EXP_W];
  assign eb = in_b[W-2 -: EXP_W];
  assign ma = in_a[MAN_W-1:0];
  assign mb = in_b[MAN_W-1:0];

  always_comb begin
    s1_d.hdr.sign  = in_a[W-1] ^ in_b[W-1];
    s1_d.hdr.cls_a = classify(ea == '0, &ea, ma == '0);
    s1_d.hdr.cls_b = classify(eb == '0, &eb, mb == '0);
    s1_d.esum      = {2'b00, ea} + {2'b00, eb} - BIAS;
    s1_d.ma        = ma;
    s1_d.mb        = mb;
    s1_d.tag       = in_tag;
  end

  always_comb begin
    s2_d.hdr  = s1_q.hdr;
    s2_d.esum = s1_q.esum;
    s2_d.prod = PW'({1'b1, s1_q.ma}) * PW'({1'b1, s1_q.mb});
    s2_d.tag  = s1_q.tag;
  end

  fp_mul_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign_i  (s2_q.hdr.sign),
    .cls_a_i (s2_q.hdr.cls_a),
    .cls_b_i (s2_q.hdr.cls_b),
    .esum_i  (s2_q.esum),
    .prod_i  (s2_q.prod),
    .data_o  (res_data),
    .ovf_o   (res_ovf),
    .unf_o   (res_unf),
    .inv_o   (res_inv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      out_inv_q   <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_data_q <= res_data;
        out_tag_q  <= s2_q.tag;
        out_ovf_q  <= res_ovf;
        out_unf_q  <= res_unf;
        out_inv_q  <= res_inv;
      end
    end
  end

  // Payload registers need no reset: the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;
  assign out_inv   = out_inv_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Randomised and directed bench for fp_mul_pipe against a real-arithmetic reference model.
module tb_fp_mul_pipe;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned TAG_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, in_tag, out_data, out_tag;
  logic        out_ovf, out_unf, out_inv;

  always #5 clk = ~clk;

  fp_mul_pipe #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_inv   (out_inv)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flags;  // {ovf, unf, inv}
    logic [31:0] tag;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_out    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Reference: exact product in double precision, rounded by value, then range-checked.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic [2:0] f);
    int     ea, eb, e;
    real    p, sc;
    longint ip;
    logic   s;
    bit     az, ai, an, bz, bi, bn;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    f  = 3'b000;
    if (an || bn || (ai && bz) || (az && bi)) begin
      d = 32'h7FC0_0000;
      f = 3'b001;
    end else if (ai || bi) begin
      d = {s, 8'hFF, 23'd0};
    end else if (az || bz) begin
      d = {s, 31'd0};
    end else begin
      p = (1.0 + real'(a[22:0]) / 8388608.0) * (1.0 + real'(b[22:0]) / 8388608.0);
      e = ea + eb - 127;
      if (p >= 2.0) begin
        p = p / 2.0;
        e++;
      end
      sc = p * 8388608.0;
      ip = longint'($floor(sc));
`ifdef FP_MUL_RNE_EN
      if ((sc - real'(ip)) > 0.5 || ((sc - real'(ip)) == 0.5 && ip[0])) ip++;
`endif
      if (ip == 64'd16777216) begin
        ip = 64'd8388608;
        e++;
      end
      if (e >= 255) begin
        d = {s, 8'hFF, 23'd0};
        f = 3'b100;
      end else if (e <= 0) begin
        d = {s, 31'd0};
        f = 3'b010;
      end else begin
        d = {s, 8'(e), ip[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int unsigned k;
    v = $urandom();
    k = $urandom_range(0, 9);
    if (k < 6)       v[30:23] = 8'($urandom_range(80, 174));
    else if (k == 7) v[30:23] = 8'h00;
    else if (k == 8) begin
      v[30:23] = 8'hFF;
      if ($urandom_range(0, 1) == 1) v[22:0] = '0;
    end else if (k == 9) begin
      v[30:23] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 30))
                                             : 8'($urandom_range(220, 254));
    end
    return v;
  endfunction

  // One clock: drive at the falling edge, sample just after, score what the next rising edge moves.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] tg, input logic ordy, input logic [31:0] ed,
                       input logic [2:0] ef, input bit lat);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_tag    = tg;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        e = sb.pop_front();
        check("data", out_data, e.data);
        check("flags", {out_ovf, out_unf, out_inv}, e.flags);
        check("tag", out_tag, e.tag);
        if (e.chk_lat) check("latency", cyc - e.acc_cyc, 3);
        n_out++;
      end
    end
    if (in_valid && in_ready) begin
      e.data    = ed;
      e.flags   = ef;
      e.tag     = tg;
      e.acc_cyc = cyc;
      e.chk_lat = lat;
      sb.push_back(e);
    end
    cyc++;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      cycle(0, 0, 0, 0, 1, 0, 0, 0);
      budget--;
    end
    if (sb.size() != 0) check(tag, sb.size(), 0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] tg,
                        input logic [31:0] ed, input logic [2:0] ef);
    cycle(1, a, b, tg, 1, ed, ef, 1);
    drain("directed_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, ed;
    logic [2:0]  ef;
    int          acc, base;
    bit          acc_now;

    rst = 1'b1;
    in_valid = 0;
    in_a = 0;
    in_b = 0;
    in_tag = 0;
    out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_flags", {out_ovf, out_unf, out_inv}, 0);
    rst = 1'b0;

    run_op(32'h4000_0000, 32'h4040_0000, 32'hA5A5_0001, 32'h40C0_0000, 3'b000);
    run_op(32'hC000_0000, 32'h4040_0000, 32'h0000_0002, 32'hC0C0_0000, 3'b000);
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h0000_0003, 32'h4010_0000, 3'b000);
`ifdef FP_MUL_RNE_EN
    run_op(32'h3F80_0001, 32'h3FC0_0000, 32'h0000_0004, 32'h3FC0_0002, 3'b000);
`else
    run_op(32'h3F80_0001, 32'h3FC0_0000, 32'h0000_0004, 32'h3FC0_0001, 3'b000);
`endif
    run_op(32'h7F00_0000, 32'h7F00_0000, 32'h0000_0005, 32'h7F80_0000, 3'b100);
    run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0006, 32'h0000_0000, 3'b010);
    run_op(32'h7F80_0000, 32'h0000_0000, 32'h0000_0007, 32'h7FC0_0000, 3'b001);
    run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h0000_0008, 32'h7FC0_0000, 3'b001);
    run_op(32'h8000_0000, 32'h4000_0000, 32'h0000_0009, 32'h8000_0000, 3'b000);
    run_op(32'h7F80_0000, 32'hC000_0000, 32'h0000_000A, 32'hFF80_0000, 3'b000);

    // Backpressure: output blocked, five operands offered.
    acc = 0;
    base = n_out;
    for (int i = 0; i < 6; i++) begin
      a = 32'h3F80_0000 + 32'(acc) * 32'h0012_3457;
      b = 32'h4000_0000 + 32'(acc) * 32'h0002_0001;
      model(a, b, ed, ef);
      cycle(acc < 5, a, b, 32'(acc + 1), 0, ed, ef, 0);
      acc_now = in_valid && in_ready;
      if (acc_now) acc++;
    end
    check("bp_accepted", acc, 3);
    check("bp_in_ready", in_ready, 0);
    check("bp_held_tag", out_tag, 1);
    check("bp_held_data", out_data, sb[0].data);
    for (int i = 0; i < 20 && !(acc == 5 && sb.size() == 0); i++) begin
      a = 32'h3F80_0000 + 32'(acc) * 32'h0012_3457;
      b = 32'h4000_0000 + 32'(acc) * 32'h0002_0001;
      model(a, b, ed, ef);
      cycle(acc < 5, a, b, 32'(acc + 1), 1, ed, ef, 0);
      acc_now = in_valid && in_ready;
      if (acc_now) acc++;
    end
    check("bp_total_out", n_out - base, 5);

    // Reset with three results in flight.
    for (int i = 0; i < 3; i++) begin
      a = rand_op();
      b = rand_op();
      model(a, b, ed, ef);
      cycle(1, a, b, 32'(16 + i), 1, ed, ef, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 0;
    out_ready = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    sb.delete();
    base = n_out;
    repeat (6) cycle(0, 0, 0, 0, 1, 0, 0, 0);
    check("no_stale", n_out - base, 0);
    run_op(32'h4000_0000, 32'h4040_0000, 32'h0000_0055, 32'h40C0_0000, 3'b000);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      a = rand_op();
      b = rand_op();
      model(a, b, ed, ef);
      cycle($urandom_range(0, 9) < 7, a, b, $urandom(), $urandom_range(0, 3) != 0, ed, ef, 0);
    end
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
